// File: rtl/mem_sched_pkg.sv
// Shared definitions for the memory channel scheduler: channel state
// encoding and the consumer-index width helper.
package mem_sched_pkg;

    // Channel FSM states (2-bit encoding)
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Width of a consumer index; never narrower than one bit so that a
    // single-consumer build still has a legal index vector.
    function automatic int cid_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_sched_rr_pick.sv
// Combinational round-robin first-set finder. Returns the first request
// that is not excluded, scanning upward from ptr with wrap-around.
module mem_sched_rr_pick #(
    parameter int N  = 8,
    parameter int IW = 3
) (
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  excl,
    input  logic [IW-1:0] ptr,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_idx
);

    logic [N-1:0] eligible;

    assign eligible = req & ~excl;

    // Scan all offsets from ptr; the first eligible index wins
    always_comb begin
        logic [IW-1:0] idx;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = '0;
        for (int off = 0; off < N; off++) begin
            idx = IW'((int'(ptr) + off) % N);
            if (!gnt_valid && eligible[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/mem_channel_scheduler.sv
// Shares NUM_CHANNELS independent memory channels among NUM_CONSUMERS LSUs.
// Each channel owns a request/response FSM and its own memory bus; idle
// channels pick consumers round-robin, lower channels claiming first.
module mem_channel_scheduler
    import mem_sched_pkg::*;
#(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 8,
    parameter int NUM_CHANNELS  = 2,
    parameter int CID_BITS      = cid_bits(NUM_CONSUMERS)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_CONSUMERS-1:0]          consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
    input  logic [NUM_CONSUMERS-1:0]          consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]          consumer_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
    output logic [NUM_CHANNELS-1:0]           mem_read_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_read_address,
    input  logic [NUM_CHANNELS-1:0]           mem_read_ready,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0] mem_read_data,
    output logic [NUM_CHANNELS-1:0]           mem_write_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_write_address,
    output logic [NUM_CHANNELS*DATA_BITS-1:0] mem_write_data,
    input  logic [NUM_CHANNELS-1:0]           mem_write_ready
);

    genvar gi;

    // Unpacked views of the consumer-side inputs
    logic [ADDR_BITS-1:0] rd_addr_in [NUM_CONSUMERS];
    logic [ADDR_BITS-1:0] wr_addr_in [NUM_CONSUMERS];
    logic [DATA_BITS-1:0] wr_data_in [NUM_CONSUMERS];
    logic [DATA_BITS-1:0] mem_rdata_in [NUM_CHANNELS];

    // Per-channel state
    logic [1:0]           state_reg   [NUM_CHANNELS];
    logic [CID_BITS-1:0]  cid_reg     [NUM_CHANNELS];
    logic [ADDR_BITS-1:0] rd_addr_reg [NUM_CHANNELS];
    logic [ADDR_BITS-1:0] wr_addr_reg [NUM_CHANNELS];
    logic [DATA_BITS-1:0] wr_data_reg [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] rd_valid_reg;
    logic [NUM_CHANNELS-1:0] wr_valid_reg;

    // Per-consumer state
    logic [NUM_CONSUMERS-1:0] busy_reg;
    logic [NUM_CONSUMERS-1:0] ready_reg;
    logic [DATA_BITS-1:0]     rdata_reg [NUM_CONSUMERS];

    logic [CID_BITS-1:0] rr_ptr_reg;
    logic [CID_BITS-1:0] rr_ptr_next;

    // Allocation signals
    logic [NUM_CONSUMERS-1:0] pending;
    logic [NUM_CHANNELS-1:0]  grant_vec;
    logic [CID_BITS-1:0]      grant_idx [NUM_CHANNELS];

    assign pending = (consumer_read_valid | consumer_write_valid) & ~busy_reg;

    generate
        for (gi = 0; gi < NUM_CONSUMERS; gi++) begin : g_cons
            assign rd_addr_in[gi] = consumer_read_address[gi*ADDR_BITS +: ADDR_BITS];
            assign wr_addr_in[gi] = consumer_write_address[gi*ADDR_BITS +: ADDR_BITS];
            assign wr_data_in[gi] = consumer_write_data[gi*DATA_BITS +: DATA_BITS];
            assign consumer_read_data[gi*DATA_BITS +: DATA_BITS] = rdata_reg[gi];
        end

        for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
            // Consumers already claimed by lower-indexed channels this cycle
            // are excluded; each stage adds its own grant to the mask.
            logic [NUM_CONSUMERS-1:0] excl_in;
            logic [NUM_CONSUMERS-1:0] excl_out;
            logic                     pick_valid;
            logic [CID_BITS-1:0]      pick_idx;
            logic                     grant;

            if (gi == 0) begin : g_head
                assign excl_in = '0;
            end else begin : g_link
                assign excl_in = g_chan[gi-1].excl_out;
            end

            mem_sched_rr_pick #(
                .N  (NUM_CONSUMERS),
                .IW (CID_BITS)
            ) u_pick (
                .req       (pending),
                .excl      (excl_in),
                .ptr       (rr_ptr_reg),
                .gnt_valid (pick_valid),
                .gnt_idx   (pick_idx)
            );

            assign grant          = pick_valid && (state_reg[gi] == ST_IDLE);
            assign excl_out       = excl_in | (grant ? (NUM_CONSUMERS'(1) << pick_idx) : '0);
            assign grant_vec[gi]  = grant;
            assign grant_idx[gi]  = pick_idx;

            assign mem_rdata_in[gi] = mem_read_data[gi*DATA_BITS +: DATA_BITS];
            assign mem_read_address[gi*ADDR_BITS +: ADDR_BITS]  = rd_addr_reg[gi];
            assign mem_write_address[gi*ADDR_BITS +: ADDR_BITS] = wr_addr_reg[gi];
            assign mem_write_data[gi*DATA_BITS +: DATA_BITS]    = wr_data_reg[gi];
        end
    endgenerate

    assign mem_read_valid  = rd_valid_reg;
    assign mem_write_valid = wr_valid_reg;
    assign consumer_ready  = ready_reg;

    // Next round-robin pointer: one past the grant made by the last granting
    // channel in scan order, so the scan resumes after the newest grant.
    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            if (grant_vec[ch]) begin
                if (grant_idx[ch] == CID_BITS'(NUM_CONSUMERS - 1)) begin
                    rr_ptr_next = '0;
                end else begin
                    rr_ptr_next = grant_idx[ch] + CID_BITS'(1);
                end
            end
        end
    end

    // Channel FSMs, busy bitmap, consumer responses and round-robin pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_reg   <= '0;
            busy_reg     <= '0;
            ready_reg    <= '0;
            rd_valid_reg <= '0;
            wr_valid_reg <= '0;
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                state_reg[ch]   <= ST_IDLE;
                cid_reg[ch]     <= '0;
                rd_addr_reg[ch] <= '0;
                wr_addr_reg[ch] <= '0;
                wr_data_reg[ch] <= '0;
            end
            for (int c = 0; c < NUM_CONSUMERS; c++) begin
                rdata_reg[c] <= '0;
            end
        end else begin
            rr_ptr_reg <= rr_ptr_next;
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                case (state_reg[ch])
                    ST_IDLE: begin
                        if (grant_vec[ch]) begin
                            cid_reg[ch]               <= grant_idx[ch];
                            busy_reg[grant_idx[ch]]   <= 1'b1;
                            // A simultaneous read and write is served as a read
                            if (consumer_read_valid[grant_idx[ch]]) begin
                                state_reg[ch]    <= ST_READ;
                                rd_valid_reg[ch] <= 1'b1;
                                rd_addr_reg[ch]  <= rd_addr_in[grant_idx[ch]];
                            end else begin
                                state_reg[ch]    <= ST_WRITE;
                                wr_valid_reg[ch] <= 1'b1;
                                wr_addr_reg[ch]  <= wr_addr_in[grant_idx[ch]];
                                wr_data_reg[ch]  <= wr_data_in[grant_idx[ch]];
                            end
                        end
                    end
                    ST_READ: begin
                        if (mem_read_ready[ch]) begin
                            rd_valid_reg[ch]           <= 1'b0;
                            rd_addr_reg[ch]            <= '0;
                            rdata_reg[cid_reg[ch]]     <= mem_rdata_in[ch];
                            ready_reg[cid_reg[ch]]     <= 1'b1;
                            state_reg[ch]              <= ST_DONE;
                        end
                    end
                    ST_WRITE: begin
                        if (mem_write_ready[ch]) begin
                            wr_valid_reg[ch]       <= 1'b0;
                            wr_addr_reg[ch]        <= '0;
                            wr_data_reg[ch]        <= '0;
                            ready_reg[cid_reg[ch]] <= 1'b1;
                            state_reg[ch]          <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        // Hold ready until the consumer withdraws every request
                        if (!consumer_read_valid[cid_reg[ch]] &&
                            !consumer_write_valid[cid_reg[ch]]) begin
                            ready_reg[cid_reg[ch]] <= 1'b0;
                            busy_reg[cid_reg[ch]]  <= 1'b0;
                            state_reg[ch]          <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_reg[ch] <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_channel_scheduler.sv
// Self-checking bench for mem_channel_scheduler: directed vector table,
// hand-written multi-cycle sequences and a randomized run against a
// transaction-level reference model.
module tb_mem_channel_scheduler;

    localparam int NC  = 8;
    localparam int NCH = 2;

    logic          clk;
    logic          reset;
    logic [7:0]    consumer_read_valid;
    logic [63:0]   consumer_read_address;
    logic [7:0]    consumer_write_valid;
    logic [63:0]   consumer_write_address;
    logic [63:0]   consumer_write_data;
    logic [7:0]    consumer_ready;
    logic [63:0]   consumer_read_data;
    logic [1:0]    mem_read_valid;
    logic [15:0]   mem_read_address;
    logic [1:0]    mem_read_ready;
    logic [15:0]   mem_read_data;
    logic [1:0]    mem_write_valid;
    logic [15:0]   mem_write_address;
    logic [15:0]   mem_write_data;
    logic [1:0]    mem_write_ready;

    int tests_run;
    int tests_failed;

    mem_channel_scheduler dut (
        .clk                    (clk),
        .reset                  (reset),
        .consumer_read_valid    (consumer_read_valid),
        .consumer_read_address  (consumer_read_address),
        .consumer_write_valid   (consumer_write_valid),
        .consumer_write_address (consumer_write_address),
        .consumer_write_data    (consumer_write_data),
        .consumer_ready         (consumer_ready),
        .consumer_read_data     (consumer_read_data),
        .mem_read_valid         (mem_read_valid),
        .mem_read_address       (mem_read_address),
        .mem_read_ready         (mem_read_ready),
        .mem_read_data          (mem_read_data),
        .mem_write_valid        (mem_write_valid),
        .mem_write_address      (mem_write_address),
        .mem_write_data         (mem_write_data),
        .mem_write_ready        (mem_write_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    int         m_owner [NCH];   // consumer served by the channel, -1 if free
    bit         m_isrd  [NCH];
    bit         m_wait  [NCH];   // request outstanding on the memory bus
    logic [7:0] m_addr  [NCH];
    logic [7:0] m_wdat  [NCH];
    int         m_rr;
    logic [7:0] m_crdy;
    logic [7:0] m_cdata [NC];

    task automatic model_step(input bit rst);
        bit [NC-1:0] busy_old;
        bit [NC-1:0] claimed;
        int          g [NCH];
        int          last;
        int          c;
        int          o;
        bit          acc;
        if (rst) begin
            for (int ch = 0; ch < NCH; ch++) begin
                m_owner[ch] = -1; m_isrd[ch] = 0; m_wait[ch] = 0;
                m_addr[ch] = '0; m_wdat[ch] = '0;
            end
            m_rr = 0; m_crdy = '0;
            for (int k = 0; k < NC; k++) m_cdata[k] = '0;
            return;
        end
        busy_old = '0;
        for (int ch = 0; ch < NCH; ch++)
            if (m_owner[ch] >= 0) busy_old[m_owner[ch]] = 1'b1;
        claimed = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            g[ch] = -1;
            if (m_owner[ch] < 0) begin
                for (int off = 0; off < NC; off++) begin
                    c = (m_rr + off) % NC;
                    if (g[ch] < 0 && (consumer_read_valid[c] || consumer_write_valid[c]) &&
                        !busy_old[c] && !claimed[c]) begin
                        g[ch] = c;
                        claimed[c] = 1'b1;
                    end
                end
            end
        end
        for (int ch = 0; ch < NCH; ch++) begin
            if (m_owner[ch] >= 0) begin
                o = m_owner[ch];
                if (m_wait[ch]) begin
                    acc = m_isrd[ch] ? mem_read_ready[ch] : mem_write_ready[ch];
                    if (acc) begin
                        m_wait[ch] = 1'b0;
                        m_crdy[o] = 1'b1;
                        if (m_isrd[ch]) m_cdata[o] = mem_read_data[ch*8 +: 8];
                    end
                end else if (!consumer_read_valid[o] && !consumer_write_valid[o]) begin
                    m_crdy[o] = 1'b0;
                    m_owner[ch] = -1;
                end
            end
        end
        last = -1;
        for (int ch = 0; ch < NCH; ch++) begin
            if (g[ch] >= 0) begin
                m_owner[ch] = g[ch];
                m_isrd[ch]  = consumer_read_valid[g[ch]];
                m_wait[ch]  = 1'b1;
                m_addr[ch]  = m_isrd[ch] ? consumer_read_address[g[ch]*8 +: 8]
                                         : consumer_write_address[g[ch]*8 +: 8];
                m_wdat[ch]  = m_isrd[ch] ? 8'h00 : consumer_write_data[g[ch]*8 +: 8];
                last = g[ch];
            end
        end
        if (last >= 0) m_rr = (last + 1) % NC;
    endtask

    task automatic model_compare(input int cyc);
        logic [1:0]  e_mrv, e_mwv;
        logic [15:0] e_mra, e_mwa, e_mwd;
        logic [63:0] e_cd;
        bit          act;
        e_mrv = '0; e_mwv = '0; e_mra = '0; e_mwa = '0; e_mwd = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            act = (m_owner[ch] >= 0) && m_wait[ch];
            if (act && m_isrd[ch]) begin
                e_mrv[ch] = 1'b1;
                e_mra[ch*8 +: 8] = m_addr[ch];
            end
            if (act && !m_isrd[ch]) begin
                e_mwv[ch] = 1'b1;
                e_mwa[ch*8 +: 8] = m_addr[ch];
                e_mwd[ch*8 +: 8] = m_wdat[ch];
            end
        end
        for (int k = 0; k < NC; k++) e_cd[k*8 +: 8] = m_cdata[k];
        chk($sformatf("rand%0d_mrv", cyc),  64'(mem_read_valid),    64'(e_mrv));
        chk($sformatf("rand%0d_mwv", cyc),  64'(mem_write_valid),   64'(e_mwv));
        chk($sformatf("rand%0d_mra", cyc),  64'(mem_read_address),  64'(e_mra));
        chk($sformatf("rand%0d_mwa", cyc),  64'(mem_write_address), 64'(e_mwa));
        chk($sformatf("rand%0d_mwd", cyc),  64'(mem_write_data),    64'(e_mwd));
        chk($sformatf("rand%0d_crdy", cyc), 64'(consumer_ready),    64'(m_crdy));
        chk($sformatf("rand%0d_cdata", cyc), consumer_read_data,    e_cd);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit         rst;
        logic [7:0] rv;
        logic [7:0] wv;
        logic [1:0] rrdy;
        logic [1:0] wrdy;
        logic [1:0] exp_mrv;
        logic [1:0] exp_mwv;
        logic [7:0] exp_crdy;
    } vec_t;

    vec_t tbl [8];

    task automatic all_idle_inputs();
        consumer_read_valid  = '0;
        consumer_write_valid = '0;
        mem_read_ready       = '0;
        mem_write_ready      = '0;
    endtask

    task automatic do_reset();
        all_idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int          got [$];
        logic [1:0]  prev_mrv;
        logic [7:0]  a;

        tests_run = 0;
        tests_failed = 0;
        reset = 1'b1;
        all_idle_inputs();
        consumer_write_address = '0;
        consumer_write_data    = '0;
        for (int c = 0; c < NC; c++) consumer_read_address[c*8 +: 8] = 8'(16 * c + 18);
        mem_read_data = 16'h5AA5;   // channel 0 returns A5, channel 1 returns 5A

        //            rst   rv     wv     rrdy   wrdy   mrv    mwv    crdy
        tbl[0] = '{1'b1, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00};
        tbl[1] = '{1'b0, 8'h08, 8'h00, 2'b01, 2'b00, 2'b01, 2'b00, 8'h00};
        tbl[2] = '{1'b0, 8'h08, 8'h00, 2'b01, 2'b00, 2'b00, 2'b00, 8'h08};
        tbl[3] = '{1'b0, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00};
        tbl[4] = '{1'b1, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00};
        tbl[5] = '{1'b0, 8'h21, 8'h00, 2'b00, 2'b00, 2'b11, 2'b00, 8'h00};
        tbl[6] = '{1'b0, 8'h00, 8'h00, 2'b11, 2'b00, 2'b00, 2'b00, 8'h21};
        tbl[7] = '{1'b0, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00};

        @(negedge clk);

        // Single read (consumer 3) and two concurrent reads (consumers 0 and 5)
        for (int i = 0; i < 8; i++) begin
            reset                = tbl[i].rst;
            consumer_read_valid  = tbl[i].rv;
            consumer_write_valid = tbl[i].wv;
            mem_read_ready       = tbl[i].rrdy;
            mem_write_ready      = tbl[i].wrdy;
            tick();
            chk($sformatf("vec%0d_mrv", i),  64'(mem_read_valid),  64'(tbl[i].exp_mrv));
            chk($sformatf("vec%0d_mwv", i),  64'(mem_write_valid), 64'(tbl[i].exp_mwv));
            chk($sformatf("vec%0d_crdy", i), 64'(consumer_ready),  64'(tbl[i].exp_crdy));
            if (tbl[i].rst) begin
                chk($sformatf("vec%0d_rst_cdata", i), consumer_read_data, 64'h0);
                chk($sformatf("vec%0d_rst_mra", i), 64'(mem_read_address), 64'h0);
            end
            if (i == 1) chk("single_addr", 64'(mem_read_address), 64'h0042);
            if (i == 2) chk("single_data", 64'(consumer_read_data[3*8 +: 8]), 64'hA5);
            if (i == 5) begin
                chk("dual_addr", 64'(mem_read_address), 64'h6212);
                chk("dual_rr_ptr", 64'(dut.rr_ptr_reg), 64'd6);
            end
            if (i == 6) chk("dual_data", 64'({consumer_read_data[5*8 +: 8], consumer_read_data[7:0]}), 64'h5AA5);
            if (i == 7) chk("dual_data_hold", 64'(consumer_read_data[5*8 +: 8]), 64'h5A);
        end

        // Fairness: all consumers re-request as soon as their ready clears
        do_reset();
        mem_read_ready = 2'b11;
        consumer_read_valid = 8'hFF;
        prev_mrv = '0;
        for (int cyc = 0; cyc < 60 && got.size() < 8; cyc++) begin
            tick();
            for (int ch = 0; ch < NCH; ch++) begin
                if (mem_read_valid[ch] && !prev_mrv[ch]) begin
                    a = mem_read_address[ch*8 +: 8];
                    got.push_back((int'(a) - 18) / 16);
                end
            end
            prev_mrv = mem_read_valid;
            consumer_read_valid = ~consumer_ready;
        end
        chk("fair_grant_count", 64'(got.size() >= 8), 64'd1);
        for (int i = 0; i < 8; i++) begin
            if (i < got.size()) chk($sformatf("fair_order%0d", i), 64'(got[i]), 64'(i));
        end

        // Backpressure: write held on channel 0 while ready is low
        do_reset();
        consumer_write_address[2*8 +: 8] = 8'h10;
        consumer_write_data[2*8 +: 8]    = 8'h77;
        consumer_write_valid = 8'h04;
        tick();
        consumer_write_address[2*8 +: 8] = 8'hEE;   // must not leak onto the bus
        consumer_write_data[2*8 +: 8]    = 8'h11;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp%0d_mwv", k),  64'(mem_write_valid),   64'h1);
            chk($sformatf("bp%0d_addr", k), 64'(mem_write_address), 64'h0010);
            chk($sformatf("bp%0d_data", k), 64'(mem_write_data),    64'h0077);
            chk($sformatf("bp%0d_crdy", k), 64'(consumer_ready),    64'h0);
            tick();
        end
        mem_write_ready = 2'b01;
        tick();
        chk("bp_done_mwv",  64'(mem_write_valid), 64'h0);
        chk("bp_done_crdy", 64'(consumer_ready),  64'h04);
        consumer_write_valid = '0;
        mem_write_ready = '0;
        tick();
        chk("bp_release_crdy", 64'(consumer_ready), 64'h0);

        // Sticky valid: consumer 1 keeps read_valid high after completion
        do_reset();
        consumer_read_valid = 8'h02;
        mem_read_ready = 2'b01;
        tick();
        chk("sticky_grant", 64'(mem_read_valid), 64'h1);
        tick();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("sticky%0d_crdy", k), 64'(consumer_ready), 64'h02);
            chk($sformatf("sticky%0d_mrv", k),  64'(mem_read_valid), 64'h0);
            tick();
        end
        consumer_read_valid = '0;
        tick();
        chk("sticky_release", 64'(consumer_ready), 64'h0);
        consumer_read_valid = 8'h02;
        mem_read_ready = '0;
        tick();
        chk("sticky_regrant", 64'(mem_read_valid), 64'h1);

        // Reset while channel 1 is mid-read
        do_reset();
        consumer_read_valid = 8'h03;
        tick();
        chk("rstmid_both_read", 64'(mem_read_valid), 64'h3);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rstmid_mrv",   64'(mem_read_valid),   64'h0);
        chk("rstmid_mra",   64'(mem_read_address), 64'h0);
        chk("rstmid_crdy",  64'(consumer_ready),   64'h0);
        chk("rstmid_busy",  64'(dut.busy_reg),     64'h0);
        consumer_read_valid = '0;
        mem_read_ready = 2'b11;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk($sformatf("rstmid_after%0d_crdy", k), 64'(consumer_ready), 64'h0);
            chk($sformatf("rstmid_after%0d_mrv", k),  64'(mem_read_valid), 64'h0);
        end

        // Randomized run against the reference model
        all_idle_inputs();
        reset = 1'b1;
        model_step(1'b1);
        tick();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            model_compare(cyc);
            reset                  = ($urandom_range(0, 199) == 0);
            consumer_read_valid    = 8'($urandom) & 8'($urandom);
            consumer_write_valid   = 8'($urandom) & 8'($urandom);
            consumer_read_address  = {$urandom, $urandom};
            consumer_write_address = {$urandom, $urandom};
            consumer_write_data    = {$urandom, $urandom};
            mem_read_ready         = 2'($urandom);
            mem_write_ready        = 2'($urandom);
            mem_read_data          = 16'($urandom);
            model_step(reset);
            tick();
        end
        model_compare(3000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_channel_scheduler.md
Name: mem_channel_scheduler

Overview:
- Shares NUM_CHANNELS independent memory channels among NUM_CONSUMERS LSUs.
- Each channel runs its own request/response FSM with its own address, data and handshake bus; there is no shared channel bus.
- Round-robin allocation: one consumer is never served by two channels, and no consumer starves.
- Sits between the LSUs of all cores and the external data-memory interface.

Parameters:
- ADDR_BITS, 8, memory address width
- DATA_BITS, 8, data word width
- NUM_CONSUMERS, 8, number of LSU requesters
- NUM_CHANNELS, 2, number of concurrent memory channels
- CID_BITS, $clog2(NUM_CONSUMERS), consumer index width (derived)

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- consumer_read_valid  in  NUM_CONSUMERS  per-LSU read request
- consumer_read_address  in  NUM_CONSUMERS*ADDR_BITS  read address, packed by consumer index
- consumer_write_valid  in  NUM_CONSUMERS  per-LSU write request
- consumer_write_address  in  NUM_CONSUMERS*ADDR_BITS  write address
- consumer_write_data  in  NUM_CONSUMERS*DATA_BITS  write data
- consumer_ready  out  NUM_CONSUMERS  transaction complete, per LSU
- consumer_read_data  out  NUM_CONSUMERS*DATA_BITS  returned read data, per LSU
- mem_read_valid  out  NUM_CHANNELS  per-channel read request
- mem_read_address  out  NUM_CHANNELS*ADDR_BITS  per-channel read address
- mem_read_ready  in  NUM_CHANNELS  per-channel read accept; data valid on the same cycle
- mem_read_data  in  NUM_CHANNELS*DATA_BITS  per-channel read data
- mem_write_valid  out  NUM_CHANNELS  per-channel write request
- mem_write_address  out  NUM_CHANNELS*ADDR_BITS  per-channel write address
- mem_write_data  out  NUM_CHANNELS*DATA_BITS  per-channel write data
- mem_write_ready  in  NUM_CHANNELS  per-channel write accept

Behaviour:

Reset:
- All outputs are 0.
- All channel FSMs return to IDLE; busy bitmap cleared; rr_ptr = 0.
- Reset mid-transaction aborts it immediately. No consumer_ready is issued for an aborted transaction.

Per-channel FSM:
- IDLE -> READ or WRITE on grant.
- READ -> DONE when mem_read_ready.
- WRITE -> DONE when mem_write_ready.
- DONE -> IDLE when the served consumer has both valids low.

Allocation (evaluated in IDLE):
- Pending(c) = (read_valid[c] | write_valid[c]) & !busy[c].
- IDLE channels are processed in ascending index. Each picks the first pending consumer scanning upward from rr_ptr with wrap-around. Consumers claimed by a lower channel in the same cycle are excluded.
- On grant at edge t:
  - Latch the consumer id.
  - Set busy[c].
  - Drive the channel's address/data from the consumer's inputs and hold them constant until accept.
  - valid is high from cycle t+1.
- rr_ptr <= (highest-order grant this cycle) + 1, mod NUM_CONSUMERS. Unchanged if no grant.
- If read_valid and write_valid are both high, the read is served. The write is not served within this transaction.

READ / WRITE states:
- mem_*_valid is held high until the matching ready.
- Accept cycle k: valid drops at k+1.
  - Read: mem_read_data is captured into consumer_read_data[c].
  - Both: consumer_ready[c] goes high at k+1.
- A ready arriving while valid is low is ignored.

DONE state:
- consumer_ready[c] is held high until the consumer drops both valids.
- On that edge: clear consumer_ready[c] and busy[c]; return to IDLE.
- The consumer may be granted again on the following edge.
- consumer_read_data[c] holds its value until the next read completion for c.

Latency and rules:
- Minimum latency, with ready on the first valid cycle: request at cycle 0 -> mem valid at cycle 1 -> consumer_ready at cycle 2.
- A consumer dropping valid before ready does not cancel the transaction; it still completes.
- Unused channels remain IDLE with outputs 0.
- Pick logic is combinational. All state and outputs are registered.

Decomposition:
- Package mem_sched_pkg holds:
  - channel state encoding (IDLE, READ, WRITE, DONE, 2 bits)
  - CID_BITS helper
- One natural sub-module, mem_sched_rr_pick: a combinational round-robin first-set finder.
  - Inputs: request mask, exclude mask, pointer.
  - Outputs: grant valid, grant index.
  - Instantiated once per channel, with exclusion masks chained.

Test Plan:
1. Single read: consumer 3 reads addr 0x42; channel 0 ready at cycle 1 with data 0xA5 -> mem_read_valid[0] high only in cycle 1, consumer_read_data[3]=0xA5 and consumer_ready[3]=1 at cycle 2, cleared the edge after valid drops.
2. Two concurrent: consumers 0 and 5 request together -> channel 0 serves 0, channel 1 serves 5 in the same cycle; no consumer granted twice; rr_ptr=6 afterwards.
3. Fairness: all 8 consumers re-request continuously with ready always high -> every consumer granted once within 4 allocation rounds; grant order 0,1 / 2,3 / 4,5 / 6,7.
4. Backpressure: write from consumer 2 (addr 0x10, data 0x77) with mem_write_ready low for 5 cycles -> valid, address and data stable throughout; consumer_ready[2] one cycle after ready.
5. Sticky valid: consumer 1 holds read_valid 3 cycles after ready -> no second grant until valid drops; consumer_ready[1] stays high for those cycles.
6. Reset mid-read: assert reset while channel 1 is in READ -> next cycle all outputs 0, busy cleared, no consumer_ready pulse.
